// File: rtl/seed_loader.sv
// Captures the free-running XNOR LFSR state on a load request, replaces the
// all-ones lock-up value with a default seed, then writes it out one row per cycle.
module seed_loader #(
  parameter int unsigned      WIDTH        = 64,
  parameter int unsigned      ROW_W        = 8,
  parameter int unsigned      NROWS        = WIDTH / ROW_W,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 64'h0123_4567_89AB_CDEF,
  localparam int unsigned     AW           = (NROWS > 1) ? $clog2(NROWS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] shift_seed,
  input  logic             load_req,
  output logic             busy,
  output logic             row_we,
  output logic [AW-1:0]    row_addr,
  output logic [ROW_W-1:0] row_data,
  output logic             done,
  output logic [WIDTH-1:0] seed_out,
  output logic             seed_subst
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    row_cnt_q, row_cnt_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             subst_q, subst_d;
  logic             rise;
  logic             all_ones;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      req_q     <= 1'b0;
      seed_q    <= '0;
      subst_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      req_q     <= req_d;
      seed_q    <= seed_d;
      subst_q   <= subst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    seed_d    = seed_q;
    subst_d   = subst_q;
    req_d     = load_req;
    rise      = load_req & ~req_q;
    all_ones  = &shift_seed;

    // Rising edges outside IDLE are dropped; req_q still tracks the level.
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          seed_d    = all_ones ? DEFAULT_SEED : shift_seed;
          subst_d   = all_ones;
          row_cnt_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (row_cnt_q == AW'(NROWS - 1)) begin
          row_cnt_d = '0;
          state_d   = DONE;
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    row_we   = (state_q == LOAD);
    done     = (state_q == DONE);
    row_addr = row_we ? row_cnt_q : '0;
    row_data = '0;
    // Row 0 carries the most significant slice of the seed.
    if (row_we) begin
      for (int unsigned r = 0; r < NROWS; r++) begin
        if (row_cnt_q == AW'(r)) begin
          row_data = seed_q[WIDTH-1-r*ROW_W -: ROW_W];
        end
      end
    end
  end

  assign seed_out   = seed_q;
  assign seed_subst = subst_q;

endmodule
